// File: rtl/parking_lot_ctrl.sv
// Parametrised N-slot parking lot controller.
// Runs a 1 s prescaler and a wrapping seconds timer, keeps per-slot occupancy and
// entry timestamps, and computes the exit fee (rate x duration, minimum fee,
// saturation). Rejected requests raise an error pulse and a held error code.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   car_enter      enter request level (synchronised), rising edge = one request
//   car_exit       exit request level (synchronised), rising edge = one request
//   car_sel        target slot index
//   slot_occupied  per-slot occupancy flags
//   occupancy      number of occupied slots
//   lot_full       high when every slot is occupied
//   timer_count    free-running seconds counter
//   cost_out       fee of the last valid exit (held)
//   cost_valid     1-cycle pulse when cost_out is loaded
//   err_pulse      1-cycle pulse on a rejected request
//   err_code       1=enter rejected, 2=exit rejected, 3=simultaneous (held)
module parking_lot_ctrl #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned TIME_W    = 10,
  parameter int unsigned COST_W    = 12,
  parameter int unsigned RATE      = 1,
  parameter int unsigned MIN_FEE   = 0,
  parameter int unsigned CLK_DIV   = 50_000_000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             car_enter,
  input  logic                             car_exit,
  input  logic [$clog2(NUM_SLOTS)-1:0]     car_sel,
  output logic [NUM_SLOTS-1:0]             slot_occupied,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   occupancy,
  output logic                             lot_full,
  output logic [TIME_W-1:0]                timer_count,
  output logic [COST_W-1:0]                cost_out,
  output logic                             cost_valid,
  output logic                             err_pulse,
  output logic [1:0]                       err_code
);

  localparam int unsigned SEL_W   = $clog2(NUM_SLOTS);
  localparam int unsigned OCC_W   = $clog2(NUM_SLOTS + 1);
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned RAW_W   = TIME_W + COST_W;
  localparam int unsigned FEE_MAX = (2 ** COST_W) - 1;

  logic [DIV_W-1:0]  presc;
  logic              tick;
  logic              enter_q;
  logic              exit_q;
  logic [TIME_W-1:0] entry_time [NUM_SLOTS];

  logic              req_en;
  logic              req_ex;
  logic              sel_ok;
  logic              sel_occ;
  logic              enter_ok;
  logic              exit_ok;
  logic [TIME_W-1:0] dur;
  logic [RAW_W-1:0]  raw;
  logic [RAW_W-1:0]  fee_clamped;
  logic [COST_W-1:0] fee;
  logic [NUM_SLOTS-1:0] slot_next;
  logic [OCC_W-1:0]  occ_next;
  logic              err_now;
  logic [1:0]        code_now;

  // Request decode, fee arithmetic and next-state values.
  always_comb begin
    tick        = (presc == DIV_W'(CLK_DIV - 1));
    req_en      = car_enter & ~enter_q;
    req_ex      = car_exit & ~exit_q;
    sel_ok      = ({1'b0, car_sel} < (SEL_W + 1)'(NUM_SLOTS));
    sel_occ     = sel_ok & slot_occupied[car_sel];
    // A simultaneous enter is dropped; only the exit proceeds.
    enter_ok    = req_en & ~req_ex & sel_ok & ~sel_occ & ~lot_full;
    exit_ok     = req_ex & sel_occ;
    // Unsigned modular subtraction keeps durations correct across timer wrap.
    dur         = timer_count - entry_time[car_sel];
    raw         = RAW_W'(dur) * RAW_W'(RATE);
    fee_clamped = raw;
    if (fee_clamped < RAW_W'(MIN_FEE)) fee_clamped = RAW_W'(MIN_FEE);
    if (fee_clamped > RAW_W'(FEE_MAX)) fee_clamped = RAW_W'(FEE_MAX);
    fee         = COST_W'(fee_clamped);

    slot_next = slot_occupied;
    if (enter_ok) slot_next[car_sel] = 1'b1;
    if (exit_ok)  slot_next[car_sel] = 1'b0;
    occ_next  = occupancy + OCC_W'(enter_ok) - OCC_W'(exit_ok);

    err_now  = 1'b0;
    code_now = 2'd0;
    if (req_en && req_ex) begin
      err_now  = 1'b1;
      code_now = 2'd3;
    end else if (req_en && !enter_ok) begin
      err_now  = 1'b1;
      code_now = 2'd1;
    end else if (req_ex && !exit_ok) begin
      err_now  = 1'b1;
      code_now = 2'd2;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc         <= '0;
      timer_count   <= '0;
      enter_q       <= 1'b0;
      exit_q        <= 1'b0;
      slot_occupied <= '0;
      occupancy     <= '0;
      lot_full      <= 1'b0;
      cost_out      <= '0;
      cost_valid    <= 1'b0;
      err_pulse     <= 1'b0;
      err_code      <= 2'd0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) entry_time[i] <= '0;
    end else begin
      enter_q       <= car_enter;
      exit_q        <= car_exit;
      presc         <= tick ? '0 : presc + DIV_W'(1);
      if (tick) timer_count <= timer_count + TIME_W'(1);
      slot_occupied <= slot_next;
      occupancy     <= occ_next;
      lot_full      <= (occ_next == OCC_W'(NUM_SLOTS));
      // Timestamp is the pre-increment value when a tick coincides.
      if (enter_ok) entry_time[car_sel] <= timer_count;
      cost_valid    <= exit_ok;
      if (exit_ok) cost_out <= fee;
      err_pulse     <= err_now;
      if (err_now) err_code <= code_now;
    end
  end

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl (4 slots, 4-bit timer, rate 2, min fee 3,
// 4-cycle prescaler). A second instance with a 4-bit fee shares the stimulus to
// exercise fee saturation.
module tb_parking_lot_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       car_enter;
  logic       car_exit;
  logic [1:0] car_sel;

  logic [3:0] slot_occupied;
  logic [2:0] occupancy;
  logic       lot_full;
  logic [3:0] timer_count;
  logic [4:0] cost_out;
  logic       cost_valid;
  logic       err_pulse;
  logic [1:0] err_code;

  logic [3:0] s_slot_occupied;
  logic [2:0] s_occupancy;
  logic       s_lot_full;
  logic [3:0] s_timer_count;
  logic [3:0] s_cost_out;
  logic       s_cost_valid;
  logic       s_err_pulse;
  logic [1:0] s_err_code;

  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  parking_lot_ctrl #(
    .NUM_SLOTS(4), .TIME_W(4), .COST_W(5), .RATE(2), .MIN_FEE(3), .CLK_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .car_enter(car_enter), .car_exit(car_exit),
    .car_sel(car_sel), .slot_occupied(slot_occupied), .occupancy(occupancy),
    .lot_full(lot_full), .timer_count(timer_count), .cost_out(cost_out),
    .cost_valid(cost_valid), .err_pulse(err_pulse), .err_code(err_code)
  );

  parking_lot_ctrl #(
    .NUM_SLOTS(4), .TIME_W(4), .COST_W(4), .RATE(2), .MIN_FEE(3), .CLK_DIV(4)
  ) dut_sat (
    .clk(clk), .reset(reset), .car_enter(car_enter), .car_exit(car_exit),
    .car_sel(car_sel), .slot_occupied(s_slot_occupied), .occupancy(s_occupancy),
    .lot_full(s_lot_full), .timer_count(s_timer_count), .cost_out(s_cost_out),
    .cost_valid(s_cost_valid), .err_pulse(s_err_pulse), .err_code(s_err_code)
  );

  // Advance n rising edges and land on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // One idle cycle, then wait (bounded) until the timer shows v.
  task automatic wait_timer(input logic [3:0] v);
    int n;
    n = 0;
    cyc(1);
    while (timer_count !== v && n < 200) begin
      cyc(1);
      n++;
    end
    if (n >= 200) begin
      $display("FAIL wait_timer: got %0d expected %0d", timer_count, v);
      n_fail++;
    end
  endtask

  task automatic pulse_enter(input logic [1:0] sel);
    car_sel = sel; car_enter = 1'b1;
    cyc(1);
    car_enter = 1'b0;
  endtask

  task automatic pulse_exit(input logic [1:0] sel);
    car_sel = sel; car_exit = 1'b1;
    cyc(1);
    car_exit = 1'b0;
  endtask

  task automatic pulse_both(input logic [1:0] sel);
    car_sel = sel; car_enter = 1'b1; car_exit = 1'b1;
    cyc(1);
    car_enter = 1'b0; car_exit = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; car_enter = 1'b0; car_exit = 1'b0; car_sel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (slot_occupied !== 4'd0) begin $display("FAIL rst_slots: got %0d expected 0", slot_occupied); n_fail++; end else n_pass++;
    if (occupancy !== 3'd0) begin $display("FAIL rst_occ: got %0d expected 0", occupancy); n_fail++; end else n_pass++;
    if (lot_full !== 1'b0) begin $display("FAIL rst_full: got %0d expected 0", lot_full); n_fail++; end else n_pass++;
    if (timer_count !== 4'd0) begin $display("FAIL rst_timer: got %0d expected 0", timer_count); n_fail++; end else n_pass++;
    if (cost_out !== 5'd0) begin $display("FAIL rst_cost: got %0d expected 0", cost_out); n_fail++; end else n_pass++;
    if (cost_valid !== 1'b0 || err_pulse !== 1'b0) begin $display("FAIL rst_pulses: got %0d/%0d expected 0/0", cost_valid, err_pulse); n_fail++; end else n_pass++;
    if (err_code !== 2'd0) begin $display("FAIL rst_errcode: got %0d expected 0", err_code); n_fail++; end else n_pass++;
    reset = 1'b0;
    cyc(3);
    if (timer_count !== 4'd0) begin $display("FAIL timer_3cyc: got %0d expected 0", timer_count); n_fail++; end else n_pass++;
    cyc(1);
    if (timer_count !== 4'd1) begin $display("FAIL timer_4cyc: got %0d expected 1", timer_count); n_fail++; end else n_pass++;
    cyc(4);
    if (timer_count !== 4'd2) begin $display("FAIL timer_8cyc: got %0d expected 2", timer_count); n_fail++; end else n_pass++;
  endtask

  task automatic test_basic_fee;
    wait_timer(4'd5);
    pulse_enter(2'd2);
    if (slot_occupied !== 4'b0100) begin $display("FAIL enter2_slots: got %b expected 0100", slot_occupied); n_fail++; end else n_pass++;
    if (occupancy !== 3'd1) begin $display("FAIL enter2_occ: got %0d expected 1", occupancy); n_fail++; end else n_pass++;
    if (err_pulse !== 1'b0) begin $display("FAIL enter2_err: got %0d expected 0", err_pulse); n_fail++; end else n_pass++;
    wait_timer(4'd12);
    pulse_exit(2'd2);
    if (cost_out !== 5'd14) begin $display("FAIL exit2_cost: got %0d expected 14", cost_out); n_fail++; end else n_pass++;
    if (cost_valid !== 1'b1) begin $display("FAIL exit2_valid: got %0d expected 1", cost_valid); n_fail++; end else n_pass++;
    if (occupancy !== 3'd0 || slot_occupied !== 4'd0) begin $display("FAIL exit2_occ: got %0d/%b expected 0/0000", occupancy, slot_occupied); n_fail++; end else n_pass++;
    cyc(1);
    if (cost_valid !== 1'b0) begin $display("FAIL exit2_valid_drop: got %0d expected 0", cost_valid); n_fail++; end else n_pass++;
    if (cost_out !== 5'd14) begin $display("FAIL exit2_cost_hold: got %0d expected 14", cost_out); n_fail++; end else n_pass++;
  endtask

  task automatic test_min_fee_and_wrap;
    wait_timer(4'd14);
    pulse_enter(2'd1);
    wait_timer(4'd15);
    pulse_enter(2'd0);
    if (occupancy !== 3'd2) begin $display("FAIL two_enter_occ: got %0d expected 2", occupancy); n_fail++; end else n_pass++;
    wait_timer(4'd0);
    pulse_exit(2'd0);
    if (cost_out !== 5'd3) begin $display("FAIL min_fee: got %0d expected 3", cost_out); n_fail++; end else n_pass++;
    if (s_cost_out !== 4'd3) begin $display("FAIL min_fee_w4: got %0d expected 3", s_cost_out); n_fail++; end else n_pass++;
    wait_timer(4'd3);
    pulse_exit(2'd1);
    if (cost_out !== 5'd10) begin $display("FAIL wrap_fee: got %0d expected 10", cost_out); n_fail++; end else n_pass++;
    if (occupancy !== 3'd0) begin $display("FAIL wrap_occ: got %0d expected 0", occupancy); n_fail++; end else n_pass++;
  endtask

  task automatic test_saturation;
    wait_timer(4'd0);
    pulse_enter(2'd3);
    wait_timer(4'd15);
    pulse_exit(2'd3);
    if (cost_out !== 5'd30) begin $display("FAIL max_fee: got %0d expected 30", cost_out); n_fail++; end else n_pass++;
    if (s_cost_out !== 4'd15) begin $display("FAIL sat_fee_w4: got %0d expected 15", s_cost_out); n_fail++; end else n_pass++;
    if (s_cost_valid !== 1'b1) begin $display("FAIL sat_valid_w4: got %0d expected 1", s_cost_valid); n_fail++; end else n_pass++;
  endtask

  task automatic test_errors;
    cyc(1);
    pulse_exit(2'd2);
    if (err_pulse !== 1'b1 || err_code !== 2'd2) begin $display("FAIL exit_empty_err: got %0d/%0d expected 1/2", err_pulse, err_code); n_fail++; end else n_pass++;
    if (cost_valid !== 1'b0 || cost_out !== 5'd30) begin $display("FAIL exit_empty_cost: got %0d/%0d expected 0/30", cost_valid, cost_out); n_fail++; end else n_pass++;
    wait_timer(4'd5);
    pulse_enter(2'd1);
    wait_timer(4'd7);
    pulse_both(2'd1);
    if (cost_out !== 5'd4 || cost_valid !== 1'b1) begin $display("FAIL simul_cost: got %0d/%0d expected 4/1", cost_out, cost_valid); n_fail++; end else n_pass++;
    if (err_pulse !== 1'b1 || err_code !== 2'd3) begin $display("FAIL simul_err: got %0d/%0d expected 1/3", err_pulse, err_code); n_fail++; end else n_pass++;
    if (occupancy !== 3'd0 || slot_occupied !== 4'd0) begin $display("FAIL simul_occ: got %0d/%b expected 0/0000", occupancy, slot_occupied); n_fail++; end else n_pass++;
    cyc(1);
    if (err_pulse !== 1'b0 || err_code !== 2'd3) begin $display("FAIL simul_hold: got %0d/%0d expected 0/3", err_pulse, err_code); n_fail++; end else n_pass++;
  endtask

  task automatic test_full;
    int cnt;
    for (int i = 0; i < 4; i++) begin
      pulse_enter(2'(i));
      cyc(1);
    end
    if (occupancy !== 3'd4 || lot_full !== 1'b1) begin $display("FAIL full_state: got %0d/%0d expected 4/1", occupancy, lot_full); n_fail++; end else n_pass++;
    if (slot_occupied !== 4'b1111) begin $display("FAIL full_slots: got %b expected 1111", slot_occupied); n_fail++; end else n_pass++;
    pulse_enter(2'd1);
    if (err_pulse !== 1'b1 || err_code !== 2'd1) begin $display("FAIL full_enter_err: got %0d/%0d expected 1/1", err_pulse, err_code); n_fail++; end else n_pass++;
    if (occupancy !== 3'd4 || slot_occupied !== 4'b1111) begin $display("FAIL full_no_change: got %0d/%b expected 4/1111", occupancy, slot_occupied); n_fail++; end else n_pass++;
    cyc(1);
    if (err_pulse !== 1'b0 || err_code !== 2'd1) begin $display("FAIL full_err_hold: got %0d/%0d expected 0/1", err_pulse, err_code); n_fail++; end else n_pass++;
    car_sel = 2'd2; car_enter = 1'b1;
    cnt = 0;
    repeat (10) begin
      cyc(1);
      if (err_pulse === 1'b1) cnt++;
    end
    car_enter = 1'b0;
    if (cnt !== 1) begin $display("FAIL held_enter_once: got %0d expected 1", cnt); n_fail++; end else n_pass++;
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    cyc(1);
    if (slot_occupied !== 4'd0 || occupancy !== 3'd0 || lot_full !== 1'b0) begin $display("FAIL mid_rst_slots: got %b/%0d/%0d expected 0000/0/0", slot_occupied, occupancy, lot_full); n_fail++; end else n_pass++;
    if (cost_out !== 5'd0 || s_cost_out !== 4'd0) begin $display("FAIL mid_rst_cost: got %0d/%0d expected 0/0", cost_out, s_cost_out); n_fail++; end else n_pass++;
    if (timer_count !== 4'd0 || err_code !== 2'd0) begin $display("FAIL mid_rst_misc: got %0d/%0d expected 0/0", timer_count, err_code); n_fail++; end else n_pass++;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fee();
    test_min_fee_and_wrap();
    test_saturation();
    test_errors();
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
